// File: rtl/wb_burst_ram_slave.sv
`timescale 1ns/1ps
// wb_burst_ram_slave
// Wishbone B3 slave RAM, 32-bit data, byte addressable, 2^AW words.
// Serves classic single cycles and registered-feedback incrementing bursts
// (linear, wrap-4/8/16). Accesses outside the BASE_ADDR window or with
// adr[1:0] != 0 are terminated with err. WAIT_STATES idle cycles precede
// the first beat of every cycle; later burst beats are back-to-back.
//
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-low reset
//   wb_adr_i, wb_dat_i    byte address, write data
//   wb_sel_i, wb_we_i     byte lane enables, write enable
//   wb_cyc_i, wb_stb_i    cycle / strobe
//   wb_cti_i, wb_bte_i    cycle type, burst wrap type
//   wb_dat_o              read data (valid with wb_ack_o)
//   wb_ack_o, wb_err_o    beat acknowledge, error termination
//   wb_rty_o              retry, always 0
module wb_burst_ram_slave #(
  parameter int unsigned AW          = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h9000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0]   mem [0:(1<<AW)-1];

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, idx_adv, adr_idx;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, hit_q;
  logic [2:0]    cti_q;
  logic [1:0]    bte_q;
  logic [31:0]   dat_q;
  logic          req, adr_hit;

  // Next index inside the burst: the wrap mask keeps the upper index bits
  // fixed and lets only the low log2(N) bits roll over.
  function automatic logic [AW-1:0] wrap_next(input logic [AW-1:0] idx,
                                               input logic [1:0]    bte);
    logic [AW-1:0] mask;
    case (bte)
      2'b01:   mask = AW'(3);
      2'b10:   mask = AW'(7);
      2'b11:   mask = AW'(15);
      default: mask = '1;
    endcase
    return (idx & ~mask) | ((idx + 1'b1) & mask);
  endfunction

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_idx = wb_adr_i[AW+1:2];
  assign adr_hit = (wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]) && (wb_adr_i[1:0] == 2'b00);
  assign idx_adv = wrap_next(idx_q, bte_q);

  // ack/err are qualified by the live cyc&stb, so a strobe dropped in the
  // ack cycle neither counts as a beat nor commits a write, and an
  // asynchronous reset of the state register removes them at once.
  assign wb_ack_o = req & hit_q & ((state_q == S_ACK) | (state_q == S_BURST));
  assign wb_err_o = req & ~hit_q & (state_q == S_ACK);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = adr_idx;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i)             state_d = S_IDLE;
        else if (cnt_q == WS_LAST) state_d = S_ACK;
        else                       cnt_d   = cnt_q + 4'd1;
      end
      S_ACK: begin
        if (!wb_cyc_i) state_d = S_IDLE;
        else if (wb_stb_i) begin
          if (hit_q && cti_q == 3'b010) begin
            state_d = S_BURST;
            idx_d   = idx_adv;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BURST: begin
        if (!wb_cyc_i) state_d = S_IDLE;
        else if (wb_stb_i) begin
          idx_d = idx_adv;
          if (wb_cti_i == 3'b111 || wb_cti_i == 3'b000) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is fetched from the index the next cycle will present, so
  // every burst beat finds its word already registered.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      cti_q   <= '0;
      bte_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dat_q   <= mem[idx_d];
      if (state_q == S_IDLE && req) begin
        we_q  <= wb_we_i;
        hit_q <= adr_hit;
        cti_q <= wb_cti_i;
        bte_q <= wb_bte_i;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_ack_o && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
`timescale 1ns/1ps
module tb_wb_burst_ram_slave;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_STATES=0, index 1: WAIT_STATES=2
  logic [31:0] adr_i [2];
  logic [31:0] dat_i [2];
  logic [3:0]  sel_i [2];
  logic        we_i  [2];
  logic        cyc_i [2];
  logic        stb_i [2];
  logic [2:0]  cti_i [2];
  logic [1:0]  bte_i [2];
  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        rty_o [2];

  wb_burst_ram_slave #(.AW(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr_i[0]), .wb_dat_i(dat_i[0]),
    .wb_sel_i(sel_i[0]), .wb_we_i(we_i[0]), .wb_cyc_i(cyc_i[0]), .wb_stb_i(stb_i[0]),
    .wb_cti_i(cti_i[0]), .wb_bte_i(bte_i[0]), .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]),
    .wb_err_o(err_o[0]), .wb_rty_o(rty_o[0]));

  wb_burst_ram_slave #(.AW(8), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut1 (
    .wb_clk(clk), .wb_rst(rst_n), .wb_adr_i(adr_i[1]), .wb_dat_i(dat_i[1]),
    .wb_sel_i(sel_i[1]), .wb_we_i(we_i[1]), .wb_cyc_i(cyc_i[1]), .wb_stb_i(stb_i[1]),
    .wb_cti_i(cti_i[1]), .wb_bte_i(bte_i[1]), .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]),
    .wb_err_o(err_o[1]), .wb_rty_o(rty_o[1]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // expected outputs for the current cycle, per DUT
  logic        exp_ack [2];
  logic        exp_err [2];
  logic        exp_rd  [2];
  logic [31:0] exp_dat [2];

  logic [31:0] mm   [2][256];   // memory image per DUT
  logic [31:0] wdat [256];      // write data per beat
  logic [31:0] rdat [256];      // observed data per beat
  logic        obs_ack, obs_err;
  logic [31:0] obs_dat;
  int          first_resp;
  bit          err0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ack%0d", d), 32'(ack_o[d]), 32'(exp_ack[d]));
        check($sformatf("err%0d", d), 32'(err_o[d]), 32'(exp_err[d]));
        check($sformatf("rty%0d", d), 32'(rty_o[d]), 32'd0);
        if (exp_rd[d]) check($sformatf("dat%0d", d), dat_o[d], exp_dat[d]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit is_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return (a[31:10] == b[31:10]) && (a[1:0] == 2'b00);
  endfunction

  // Word index of beat k of a burst starting at word s.
  function automatic logic [7:0] beat_idx(input logic [7:0] s, input int k, input logic [1:0] bte);
    int n, si;
    n  = (bte == 2'b00) ? 256 : (2 << bte);
    si = int'(s);
    return 8'((si / n) * n + (si % n + k) % n);
  endfunction

  task automatic step(input int d, input bit cy, input bit st, input logic [31:0] ad,
                      input bit we, input logic [31:0] dt, input logic [3:0] sl,
                      input logic [2:0] ct, input logic [1:0] bt,
                      input bit ea, input bit ee, input logic [31:0] ed);
    @(posedge clk); #1;
    cyc_i[d] = cy; stb_i[d] = st; adr_i[d] = ad; we_i[d] = we;
    dat_i[d] = dt; sel_i[d] = sl; cti_i[d] = ct; bte_i[d] = bt;
    exp_ack[d] = ea; exp_err[d] = ee; exp_rd[d] = ea & ~we; exp_dat[d] = ed;
    @(negedge clk);
    obs_ack = ack_o[d]; obs_err = err_o[d]; obs_dat = dat_o[d];
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // One bus cycle timed from the rules: response in cycle 1+WS after the
  // request cycle, then one beat per strobed cycle.
  task automatic xfer(input int d, input logic [31:0] a, input bit we, input int n_in,
                      input logic [1:0] bte, input logic [3:0] sel, input int stall_at,
                      input bit rnd_stall, input bit keep);
    int ws, n, c;
    bit h;
    logic [7:0] s, ix;
    logic [31:0] ad;
    logic [2:0] ct;
    ws = (d == 0) ? 0 : 2;
    h  = is_hit(a);
    n  = h ? n_in : 1;
    s  = a[9:2];
    c  = 0;
    first_resp = -1;
    err0 = 1'b0;
    for (int w = 0; w <= ws; w++) begin
      step(d, 1'b1, 1'b1, a, we, wdat[0], sel, (n == 1) ? 3'b000 : 3'b010, bte, 1'b0, 1'b0, '0);
      if (first_resp < 0 && (obs_ack || obs_err)) first_resp = c;
      c++;
    end
    for (int k = 0; k < n; k++) begin
      ix = beat_idx(s, k, bte);
      ad = (k == 0) ? a : {a[31:10], ix, 2'b00};
      ct = (n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
      if (k > 0 && (k == stall_at || (rnd_stall && $urandom_range(3) == 0))) begin
        step(d, 1'b1, 1'b0, ad, we, wdat[k], sel, ct, bte, 1'b0, 1'b0, '0);
        c++;
      end
      step(d, 1'b1, 1'b1, ad, we, wdat[k], sel, ct, bte, h, !h, mm[d][ix]);
      if (first_resp < 0 && (obs_ack || obs_err)) first_resp = c;
      if (k == 0) err0 = obs_err;
      rdat[k] = obs_dat;
      c++;
      if (h && we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mm[d][ix][8*b +: 8] = wdat[k][8*b +: 8];
    end
    if (!keep) idle(d);
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] base_v, a;
    logic [7:0]  ix8;
    int d, n, r;
    bit keep, prev_keep;

    wrap_exp = '{32'h12, 32'h13, 32'h10, 32'h11};
    base_v = BASE;
    for (int i = 0; i < 2; i++) begin
      cyc_i[i] = 0; stb_i[i] = 0; adr_i[i] = '0; we_i[i] = 0; dat_i[i] = '0;
      sel_i[i] = '0; cti_i[i] = '0; bte_i[i] = '0;
      exp_ack[i] = 0; exp_err[i] = 0; exp_rd[i] = 0; exp_dat[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ack%0d", i), 32'(ack_o[i]), 32'd0);
      check($sformatf("rst_err%0d", i), 32'(err_o[i]), 32'd0);
      check($sformatf("rst_rty%0d", i), 32'(rty_o[i]), 32'd0);
      check($sformatf("rst_dat%0d", i), dat_o[i], 32'd0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // give every word a known value
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) wdat[k] = $urandom;
      xfer(i, BASE, 1'b1, 256, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    end

    wdat[0] = 32'hDEAD_BEEF;
    xfer(0, BASE, 1'b1, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    xfer(0, BASE, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("rd_deadbeef", rdat[0], 32'hDEAD_BEEF);
    check("latency_ws0", 32'(first_resp), 32'd1);

    wdat[0] = 32'h0000_00AA;
    xfer(0, BASE, 1'b1, 1, 2'b00, 4'b0001, -1, 1'b0, 1'b0);
    xfer(0, BASE, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("rd_bytelane", rdat[0], 32'hDEAD_BEAA);

    xfer(0, 32'h8000_0000, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("err_window", 32'(err0), 32'd1);
    xfer(0, 32'h9000_0002, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("err_misalign", 32'(err0), 32'd1);
    xfer(0, BASE, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("rd_after_err", rdat[0], 32'hDEAD_BEAA);

    for (int k = 0; k < 4; k++) wdat[k] = 32'h10 + 32'(k);
    xfer(0, BASE, 1'b1, 4, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    wdat[0] = 32'h55;
    xfer(0, BASE + 32'd16, 1'b1, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);

    xfer(0, BASE + 32'd8, 1'b0, 4, 2'b01, 4'hF, -1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("wrap4_b%0d", k), rdat[k], wrap_exp[k]);
    xfer(0, BASE + 32'd8, 1'b0, 4, 2'b01, 4'hF, 2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("wrap4_stall_b%0d", k), rdat[k], wrap_exp[k]);

    wdat[0] = 32'h1234_5678;
    xfer(1, BASE + 32'd20, 1'b1, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    xfer(1, BASE + 32'd20, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("rd_ws2", rdat[0], 32'h1234_5678);
    check("latency_ws2", 32'(first_resp), 32'd3);

    // cyc withdrawn while waiting; the next request must see full latency
    step(1, 1'b1, 1'b1, BASE + 32'd20, 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0, '0);
    repeat (3) idle(1);
    xfer(1, BASE + 32'd20, 1'b0, 1, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("latency_after_abort", 32'(first_resp), 32'd3);

    // linear write burst cut by reset during its third beat
    step(0, 1'b1, 1'b1, BASE + 32'd8, 1'b1, 32'hA0, 4'hF, 3'b010, 2'b00, 1'b0, 1'b0, '0);
    step(0, 1'b1, 1'b1, BASE + 32'd8, 1'b1, 32'hA0, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0, '0);
    mm[0][2] = 32'hA0;
    step(0, 1'b1, 1'b1, BASE + 32'd12, 1'b1, 32'hA1, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0, '0);
    mm[0][3] = 32'hA1;
    @(posedge clk); #1;
    adr_i[0] = BASE + 32'd16; dat_i[0] = 32'hA2; exp_ack[0] = 1'b1;
    #1 check("ack_before_rst", 32'(ack_o[0]), 32'd1);
    rst_n = 1'b0; exp_ack[0] = 1'b0;
    #1 check("ack_at_rst", 32'(ack_o[0]), 32'd0);
    cyc_i[0] = 1'b0; stb_i[0] = 1'b0; we_i[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(0, BASE + 32'd8, 1'b0, 3, 2'b00, 4'hF, -1, 1'b0, 1'b0);
    check("rst_word2", rdat[0], 32'hA0);
    check("rst_word3", rdat[1], 32'hA1);
    check("rst_word4", rdat[2], 32'h55);

    // randomized traffic on both slaves
    prev_keep = 1'b0;
    d = 0;
    for (int i = 0; i < 300; i++) begin
      if (!prev_keep) d = int'($urandom_range(1));
      r   = int'($urandom_range(9));
      ix8 = 8'($urandom);
      a   = {base_v[31:10], ix8, 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(3, 1));
      else if (r == 1) a[31:10] = a[31:10] ^ 22'($urandom_range(4194303, 1));
      n = ($urandom_range(1) == 0) ? 1 : int'($urandom_range(8, 2));
      for (int k = 0; k < n; k++) wdat[k] = $urandom;
      keep = ($urandom_range(3) == 0);
      xfer(d, a, 1'($urandom_range(1)), n, 2'($urandom_range(3)), 4'($urandom),
           -1, 1'b1, keep);
      prev_keep = keep;
    end
    idle(0);
    idle(1);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
